color_register_axil_slave: RTL

//  AXI4-Lite slave at the far end of the colour-register bus: answers master writes/reads to
//  NUM_REGS 32-bit shadow registers and drives the renderer's palette outputs.

---
 rtl/color_reg_pkg.sv | 23 ++
 rtl/color_reg_wr_fsm.sv | 101 ++++++++++
 rtl/color_register_axil_slave.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/color_reg_pkg.sv
// Shared constants and FSM state types for the colour-register AXI4-Lite slave.
package color_reg_pkg;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    localparam logic [3:0] COLOR0 = 4'h0;
    localparam logic [3:0] COLOR1 = 4'h4;
    localparam logic [3:0] COLOR2 = 4'h8;
    localparam logic [3:0] COLOR3 = 4'hC;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_HAVE_AW,
        WR_HAVE_W,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_e;

endpackage

// File: rtl/color_reg_wr_fsm.sv
// AXI4-Lite write path: independent AW/W capture, one-cycle write strobe, B channel.
// Strobe and BVALID one edge after the later handshake; readies held low until B completes.
module color_reg_wr_fsm
    import color_reg_pkg::*;
#(
    parameter int IDX_W  = 2,
    parameter int DATA_W = 32
) (
    input  logic                  core_clk,
    input  logic                  arst_n,
    input  logic                  aw_vld,
    output logic                  aw_rdy,
    input  logic [IDX_W-1:0]      aw_idx,
    input  logic                  w_vld,
    output logic                  w_rdy,
    input  logic [DATA_W-1:0]     w_dat,
    input  logic [DATA_W/8-1:0]   w_strb,
    output logic                  b_vld,
    input  logic                  b_rdy,
    output logic                  wr_en,
    output logic [IDX_W-1:0]      wr_idx,
    output logic [DATA_W-1:0]     wr_dat,
    output logic [DATA_W/8-1:0]   wr_strb
);

    wr_state_e             state_q, state_d;
    logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]     w_dat_q, w_dat_d;
    logic [DATA_W/8-1:0]   w_strb_q, w_strb_d;
    logic                  aw_rdy_q, aw_rdy_d;
    logic                  w_rdy_q, w_rdy_d;
    logic                  b_vld_q, b_vld_d;
    logic                  aw_hs, w_hs;

    assign aw_hs = aw_vld & aw_rdy_q;
    assign w_hs  = w_vld & w_rdy_q;

    always_comb begin
        state_d  = state_q;
        aw_idx_d = aw_idx_q;
        w_dat_d  = w_dat_q;
        w_strb_d = w_strb_q;
        b_vld_d  = b_vld_q;
        wr_en    = 1'b0;
        if (aw_hs) aw_idx_d = aw_idx;
        if (w_hs) begin
            w_dat_d  = w_dat;
            w_strb_d = w_strb;
        end
        unique case (state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) state_d = WR_RESP;
                else if (aw_hs)    state_d = WR_HAVE_AW;
                else if (w_hs)     state_d = WR_HAVE_W;
            end
            WR_HAVE_AW: if (w_hs)  state_d = WR_RESP;
            WR_HAVE_W:  if (aw_hs) state_d = WR_RESP;
            WR_RESP: begin
                // First cycle in WR_RESP commits the write; later cycles only wait on BREADY.
                if (!b_vld_q) begin
                    wr_en   = 1'b1;
                    b_vld_d = 1'b1;
                end else if (b_rdy) begin
                    b_vld_d = 1'b0;
                    state_d = WR_IDLE;
                end
            end
            default: state_d = WR_IDLE;
        endcase
        aw_rdy_d = (state_d == WR_IDLE) || (state_d == WR_HAVE_W);
        w_rdy_d  = (state_d == WR_IDLE) || (state_d == WR_HAVE_AW);
    end

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q  <= WR_IDLE;
            aw_idx_q <= '0;
            w_dat_q  <= '0;
            w_strb_q <= '0;
            aw_rdy_q <= 1'b0;
            w_rdy_q  <= 1'b0;
            b_vld_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            aw_idx_q <= aw_idx_d;
            w_dat_q  <= w_dat_d;
            w_strb_q <= w_strb_d;
            aw_rdy_q <= aw_rdy_d;
            w_rdy_q  <= w_rdy_d;
            b_vld_q  <= b_vld_d;
        end
    end

    assign aw_rdy  = aw_rdy_q;
    assign w_rdy   = w_rdy_q;
    assign b_vld   = b_vld_q;
    assign wr_idx  = aw_idx_q;
    assign wr_dat  = w_dat_q;
    assign wr_strb = w_strb_q;

endmodule

// File: rtl/color_register_axil_slave.sv
// AXI4-Lite shadow palette registers, committed to color_o on vsync_i; read data one edge after AR.
// One read and one write outstanding; READY stays low until the matching R/B handshake.
module color_register_axil_slave
    import color_reg_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int COLOR_WIDTH        = 24,
    localparam int NUM_REGS          = 2**(C_S_AXI_ADDR_WIDTH-2),
    localparam int IDX_W             = C_S_AXI_ADDR_WIDTH-2
) (
    input  logic                              ACLK,
    input  logic                              ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
    input  logic [2:0]                        S_AXI_AWPROT,
    input  logic                              S_AXI_AWVALID,
    output logic                              S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
    input  logic                              S_AXI_WVALID,
    output logic                              S_AXI_WREADY,
    output logic [1:0]                        S_AXI_BRESP,
    output logic                              S_AXI_BVALID,
    input  logic                              S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
    input  logic [2:0]                        S_AXI_ARPROT,
    input  logic                              S_AXI_ARVALID,
    output logic                              S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
    output logic [1:0]                        S_AXI_RRESP,
    output logic                              S_AXI_RVALID,
    input  logic                              S_AXI_RREADY,
    input  logic                              vsync_i,
    output logic [NUM_REGS*COLOR_WIDTH-1:0]   color_o,
    output logic                              dirty_o
);

    logic [C_S_AXI_DATA_WIDTH-1:0]   shadow_q [NUM_REGS];
    logic [C_S_AXI_DATA_WIDTH-1:0]   shadow_d [NUM_REGS];
    logic [NUM_REGS*COLOR_WIDTH-1:0] color_q, color_d;
    logic                            dirty_q, dirty_d;
    rd_state_e                       rd_state_q, rd_state_d;
    logic                            ar_rdy_q, ar_rdy_d;
    logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_q, rdata_d;

    logic                            wr_en;
    logic [IDX_W-1:0]                wr_idx;
    logic [C_S_AXI_DATA_WIDTH-1:0]   wr_dat;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
    logic                            unused_ok;

    assign unused_ok = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0], S_AXI_AWPROT, S_AXI_ARPROT};

    color_reg_wr_fsm #(
        .IDX_W  (IDX_W),
        .DATA_W (C_S_AXI_DATA_WIDTH)
    ) u_wr_fsm (
        .core_clk (ACLK),
        .arst_n   (ARESETN),
        .aw_vld   (S_AXI_AWVALID),
        .aw_rdy   (S_AXI_AWREADY),
        .aw_idx   (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
        .w_vld    (S_AXI_WVALID),
        .w_rdy    (S_AXI_WREADY),
        .w_dat    (S_AXI_WDATA),
        .w_strb   (S_AXI_WSTRB),
        .b_vld    (S_AXI_BVALID),
        .b_rdy    (S_AXI_BREADY),
        .wr_en    (wr_en),
        .wr_idx   (wr_idx),
        .wr_dat   (wr_dat),
        .wr_strb  (wr_strb)
    );

    // Commit samples the pre-write shadow; a same-edge write still leaves dirty set.
    always_comb begin
        shadow_d = shadow_q;
        color_d  = color_q;
        dirty_d  = dirty_q;
        if (vsync_i) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                color_d[k*COLOR_WIDTH +: COLOR_WIDTH] = shadow_q[k][COLOR_WIDTH-1:0];
            end
            dirty_d = 1'b0;
        end
        if (wr_en) begin
            for (int b = 0; b < C_S_AXI_DATA_WIDTH/8; b++) begin
                if (wr_strb[b]) shadow_d[wr_idx][b*8 +: 8] = wr_dat[b*8 +: 8];
            end
            dirty_d = 1'b1;
        end
    end

    always_comb begin
        rd_state_d = rd_state_q;
        ar_rdy_d   = ar_rdy_q;
        rdata_d    = rdata_q;
        unique case (rd_state_q)
            RD_IDLE: begin
                ar_rdy_d = 1'b1;
                if (S_AXI_ARVALID && ar_rdy_q) begin
                    rd_state_d = RD_DATA;
                    rdata_d    = shadow_q[S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2]];
                    ar_rdy_d   = 1'b0;
                end
            end
            RD_DATA: begin
                if (S_AXI_RREADY) begin
                    rd_state_d = RD_IDLE;
                    ar_rdy_d   = 1'b1;
                end
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            shadow_q   <= '{default: '0};
            color_q    <= '0;
            dirty_q    <= 1'b0;
            rd_state_q <= RD_IDLE;
            ar_rdy_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            shadow_q   <= shadow_d;
            color_q    <= color_d;
            dirty_q    <= dirty_d;
            rd_state_q <= rd_state_d;
            ar_rdy_q   <= ar_rdy_d;
            rdata_q    <= rdata_d;
        end
    end

    assign S_AXI_ARREADY = ar_rdy_q;
    assign S_AXI_RVALID  = (rd_state_q == RD_DATA);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = AXI_RESP_OKAY;
    assign S_AXI_BRESP   = AXI_RESP_OKAY;
    assign color_o       = color_q;
    assign dirty_o       = dirty_q;

endmodule
